// File: rtl/uart_rx.sv
// UART 8N1 receiver: oversamples the rx line, samples each bit at mid-bit,
// and holds the last good byte in a one-entry buffer with valid/ack handshake.
module uart_rx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_en,
    input  logic       rx,
    input  logic       data_ack,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       end_flag,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy_flag
);

    localparam int CLK_COUNT_BIT  = CLK_FREQ / BAUD_RATE;
    localparam int CLK_COUNT_HALF = CLK_COUNT_BIT / 2;
    localparam logic [31:0] BIT_LIMIT  = 32'(CLK_COUNT_BIT - 1);
    localparam logic [31:0] HALF_LIMIT = 32'(CLK_COUNT_HALF - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state;
    logic        rx_meta;
    logic        rx_s;
    logic [31:0] clk_count;
    logic [2:0]  bit_count;
    logic [7:0]  shift_reg;

    // Two-stage synchronizer; both stages reset to the idle-high line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            clk_count  <= 32'd0;
            bit_count  <= 3'd0;
            shift_reg  <= 8'h00;
            data       <= 8'h00;
            data_valid <= 1'b0;
            end_flag   <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy_flag  <= 1'b0;
        end else begin
            end_flag <= 1'b0;

            // Consumer read; a good byte completing this same cycle overrides below.
            if (data_ack && data_valid) begin
                data_valid <= 1'b0;
                overrun    <= 1'b0;
            end

            case (state)
                IDLE: begin
                    clk_count <= 32'd0;
                    bit_count <= 3'd0;
                    if (rx_en && !rx_s) begin
                        state     <= START;
                        busy_flag <= 1'b1;
                    end
                end

                START: begin
                    if (clk_count == HALF_LIMIT) begin
                        clk_count <= 32'd0;
                        if (rx_s) begin
                            state     <= IDLE;
                            busy_flag <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        clk_count <= clk_count + 32'd1;
                    end
                end

                DATA: begin
                    if (clk_count == BIT_LIMIT) begin
                        clk_count            <= 32'd0;
                        shift_reg[bit_count] <= rx_s;
                        bit_count            <= bit_count + 3'd1;
                        if (bit_count == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        clk_count <= clk_count + 32'd1;
                    end
                end

                STOP: begin
                    // Leave at mid stop bit so a back-to-back start edge is seen.
                    if (clk_count == BIT_LIMIT) begin
                        clk_count <= 32'd0;
                        state     <= IDLE;
                        busy_flag <= 1'b0;
                        if (rx_s) begin
                            data       <= shift_reg;
                            data_valid <= 1'b1;
                            end_flag   <= 1'b1;
                            frame_err  <= 1'b0;
                            if (data_valid && !data_ack) begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        clk_count <= clk_count + 32'd1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    busy_flag <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames driven at a reduced baud ratio; a queue
// scoreboard checks every end_flag byte and latency, plus flag state checks.
module tb_uart_rx;

    localparam int CLK_FREQ  = 4000;
    localparam int BAUD_RATE = 100;
    localparam int BIT  = CLK_FREQ / BAUD_RATE;
    localparam int HALF = BIT / 2;
    localparam int LAT  = 2 + 1 + HALF + 9 * BIT;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_en;
    logic       rx;
    logic       data_ack;
    logic [7:0] data;
    logic       data_valid;
    logic       end_flag;
    logic       frame_err;
    logic       overrun;
    logic       busy_flag;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] exp_q[$];
    int         lat_q[$];

    // Reference model of the visible register state
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_overrun;
    logic       m_ferr;

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
        .clk(clk), .reset(reset), .rx_en(rx_en), .rx(rx), .data_ack(data_ack),
        .data(data), .data_valid(data_valid), .end_flag(end_flag),
        .frame_err(frame_err), .overrun(overrun), .busy_flag(busy_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every end_flag cycle must match the oldest expected byte.
    always @(negedge clk) begin
        cyc++;
        if (end_flag === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_end_flag", 32'(data), 32'hFFFF_FFFF);
            end else begin
                int d;
                chk("end_flag_data", 32'(data), 32'(exp_q.pop_front()));
                d = cyc - lat_q.pop_front() - 1;
                chk("latency_window", 32'(d >= LAT - 2 && d <= LAT + 2), 32'd1);
            end
        end
    end

    // Model: good frame -> new byte (overrun if unread), bad stop -> frame_err.
    task automatic model_frame(input logic [7:0] b, input logic stop_ok, input logic ack_same);
        if (stop_ok) begin
            exp_q.push_back(b);
            lat_q.push_back(cyc);
            if (m_valid && !ack_same) m_overrun = 1'b1;
            if (ack_same) m_overrun = 1'b0;
            m_data  = b;
            m_valid = 1'b1;
            m_ferr  = 1'b0;
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    task automatic send_line(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
        rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(posedge clk);
        #1;
        if (rx_en) model_frame(b, stop_bit, 1'b0);
        send_line(b, stop_bit);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ack_pulse();
        @(posedge clk);
        #1 data_ack = 1'b1;
        @(posedge clk);
        #1 data_ack = 1'b0;
        if (m_valid) begin
            m_valid   = 1'b0;
            m_overrun = 1'b0;
        end
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        chk({tag, "_data"}, 32'(data), 32'(m_data));
        chk({tag, "_valid"}, 32'(data_valid), 32'(m_valid));
        chk({tag, "_overrun"}, 32'(overrun), 32'(m_overrun));
        chk({tag, "_frame_err"}, 32'(frame_err), 32'(m_ferr));
        chk({tag, "_busy"}, 32'(busy_flag), 32'd0);
        #1;
    endtask

    task automatic model_reset();
        m_data = 8'h00; m_valid = 1'b0; m_overrun = 1'b0; m_ferr = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        logic       ok;
        logic       seen_busy;

        rx = 1'b1; rx_en = 1'b1; data_ack = 1'b0; reset = 1'b1;
        model_reset();
        idle(5);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_end_flag", 32'(end_flag), 32'd0);
        check_state("reset");

        // Good frame, then a framing error that leaves data untouched, then recovery
        send_frame(8'h55, 1'b1); idle(2 * BIT); check_state("byte55");
        send_frame(8'hA5, 1'b0); idle(2 * BIT); check_state("bad_stop");
        send_frame(8'h0F, 1'b1); idle(2 * BIT); check_state("recover0F");

        // Short glitch: START times out, no output change
        seen_busy = 1'b0;
        @(posedge clk); #1 rx = 1'b0;
        repeat (HALF / 2) begin
            @(negedge clk);
            seen_busy = seen_busy | busy_flag;
        end
        #1 rx = 1'b1;
        idle(2 * BIT);
        chk("glitch_busy_seen", 32'(seen_busy), 32'd1);
        check_state("glitch");

        // Back-to-back without ack -> overrun, then ack clears
        ack_pulse();
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        idle(2 * BIT); check_state("overrun");
        ack_pulse(); check_state("ack_clear");

        // Ack coinciding with a new good byte: new byte wins, overrun not set
        send_frame(8'h5A, 1'b1); idle(BIT);
        fork
            begin
                @(posedge clk); #1;
                model_frame(8'hC3, 1'b1, 1'b1);
                send_line(8'hC3, 1'b1);
            end
            begin
                @(posedge clk);
                repeat (LAT - 1) @(posedge clk);
                #1 data_ack = 1'b1;
                @(posedge clk);
                #1 data_ack = 1'b0;
            end
        join
        idle(2 * BIT); check_state("ack_collide");

        // Reset during data bit 4 discards the partial byte
        @(posedge clk); #1;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'hE7 >> i));
        rx = 1'b1 & 1'(8'hE7 >> 4);
        repeat (HALF) @(posedge clk);
        #1 reset = 1'b1; rx = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        model_reset();
        @(negedge clk);
        chk("midreset_end_flag", 32'(end_flag), 32'd0);
        check_state("midreset");
        idle(2 * BIT);
        send_frame(8'h3C, 1'b1); idle(2 * BIT); check_state("after_reset");

        // rx_en low: frame ignored entirely
        rx_en = 1'b0;
        seen_busy = 1'b0;
        fork
            send_frame(8'h99, 1'b1);
            repeat (11 * BIT) begin
                @(negedge clk);
                seen_busy = seen_busy | busy_flag;
            end
        join
        idle(2 * BIT);
        chk("rx_en_off_busy", 32'(seen_busy), 32'd0);
        check_state("rx_en_off");
        rx_en = 1'b1;

        // rx_en dropped mid-frame: that frame still completes
        fork
            send_frame(8'h6B, 1'b1);
            begin idle(3 * BIT); rx_en = 1'b0; end
        join
        idle(2 * BIT); check_state("rx_en_mid");
        rx_en = 1'b1;

        // Loopback-style corner bytes
        send_frame(8'h00, 1'b1); idle(2 * BIT);
        send_frame(8'hFF, 1'b1); idle(2 * BIT); ack_pulse();
        send_frame(8'h80, 1'b1); idle(2 * BIT); check_state("corner");

        // Randomized frames, stop bits and acks
        for (int n = 0; n < 12; n++) begin
            b  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 4) != 0);
            send_frame(b, ok);
            idle(2 * BIT + int'($urandom_range(0, 20)));
            if ($urandom_range(0, 1) == 1) ack_pulse();
            check_state("random");
        end

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
